nibble_packer: RTL and testbench

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_packer.sv | 128 ++++++++++++
 tb/tb_nibble_packer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_packer.sv
// nibble_packer: packs pairs of 4-bit nibbles into bytes.
// A frame that ends on an odd nibble is completed with PAD.
// The output is a single-entry register slice; a new byte may load on the
// same edge the current one is taken, so a steady stream loses no cycles.
//
// Handshake rule (both sides): a transfer happens on a rising edge exactly when
// valid and ready are both 1; once raised, out_valid and its payload
// stay unchanged until that transfer, and ready never depends on valid.
module nibble_packer #(
    parameter int          MSB_FIRST = 1,
    parameter logic [3:0]  PAD       = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  in_nib,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] byte_cnt,
    output logic        half
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  hi_q, hi_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;

    logic        would_produce;
    logic        in_xfer;
    logic        out_xfer;
    logic        produce;
    logic [3:0]  first_nib;
    logic [3:0]  second_nib;

    // Handshake terms: a nibble that would complete a byte needs a free output slot.
    always_comb begin
        would_produce = (state_q == HALF) || in_last;
        in_ready      = rst_n && (!would_produce || !out_valid_q || out_ready);
        in_xfer       = in_valid && in_ready;
        out_xfer      = out_valid_q && out_ready;
        produce       = in_xfer && would_produce;
    end

    // State register (EMPTY / HALF).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an odd nibble without in_last is parked, anything else returns to EMPTY.
    always_comb begin
        state_d = state_q;
        if (in_xfer) begin
            case (state_q)
                EMPTY:   state_d = in_last ? EMPTY : HALF;
                HALF:    state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Output/datapath: held nibble, output slice and transfer counter.
    always_comb begin
        first_nib   = (state_q == HALF) ? hi_q : in_nib;
        second_nib  = (state_q == HALF) ? in_nib : PAD;
        hi_d        = hi_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        byte_cnt_d  = byte_cnt_q + {15'd0, out_xfer};

        if (in_xfer && (state_q == EMPTY) && !in_last) begin
            hi_d = in_nib;
        end

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (produce) begin
            out_valid_d = 1'b1;
            out_last_d  = (state_q == HALF) ? in_last : 1'b1;
            if (MSB_FIRST != 0) begin
                out_data_d = {first_nib, second_nib};
            end else begin
                out_data_d = {second_nib, first_nib};
            end
        end
    end

    // Datapath registers; reset drops any held nibble and any pending byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q        <= 4'h0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            byte_cnt_q  <= 16'h0000;
        end else begin
            hi_q        <= hi_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign byte_cnt  = byte_cnt_q;
    assign half      = (state_q == HALF);

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: two instances share one stimulus stream, one packing
// MSB-first with PAD=0, the other LSB-first with PAD=5. Directed nibbles
// push hand-computed {last,byte} pairs into per-instance queues; a monitor
// pops and compares on every output transfer.
module tb_nibble_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_nib;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_m, out_valid_m, out_last_m, half_m;
    logic [7:0]  out_data_m;
    logic [15:0] byte_cnt_m;
    logic        in_ready_l, out_valid_l, out_last_l, half_l;
    logic [7:0]  out_data_l;
    logic [15:0] byte_cnt_l;

    int total;
    int bad;
    int cyc;

    logic [8:0]  exp_q[$];
    logic [8:0]  exp_l[$];
    logic [15:0] model_cnt;
    logic        hold_seen;
    logic [8:0]  hold_val;

    nibble_packer #(.MSB_FIRST(1), .PAD(4'h0)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_nib(in_nib),
        .in_last(in_last), .in_ready(in_ready_m), .out_valid(out_valid_m),
        .out_data(out_data_m), .out_last(out_last_m), .out_ready(out_ready),
        .byte_cnt(byte_cnt_m), .half(half_m)
    );

    nibble_packer #(.MSB_FIRST(0), .PAD(4'h5)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_nib(in_nib),
        .in_last(in_last), .in_ready(in_ready_l), .out_valid(out_valid_l),
        .out_data(out_data_l), .out_last(out_last_l), .out_ready(out_ready),
        .byte_cnt(byte_cnt_l), .half(half_l)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: a transfer happens at the next posedge when valid&&ready here.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_cnt = 16'h0000;
            hold_seen = 1'b0;
        end else begin
            if (hold_seen && out_valid_m) begin
                check("hold_stable", {23'd0, out_last_m, out_data_m}, {23'd0, hold_val});
            end
            hold_seen = out_valid_m && !out_ready;
            hold_val  = {out_last_m, out_data_m};
            if (out_valid_m && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("msb_unexpected_byte", {23'd0, out_last_m, out_data_m}, 32'hFFFF_FFFF);
                end else begin
                    check("msb_byte", {23'd0, out_last_m, out_data_m}, {23'd0, exp_q.pop_front()});
                end
                check("byte_cnt", {16'd0, byte_cnt_m}, {16'd0, model_cnt});
                model_cnt = model_cnt + 16'd1;
            end
            if (out_valid_l && out_ready) begin
                if (exp_l.size() == 0) begin
                    check("lsb_unexpected_byte", {23'd0, out_last_l, out_data_l}, 32'hFFFF_FFFF);
                end else begin
                    check("lsb_byte", {23'd0, out_last_l, out_data_l}, {23'd0, exp_l.pop_front()});
                end
            end
        end
    end

    // Driver: present one nibble; called at posedge+1, returns at posedge+1 after it is taken.
    task automatic send(input logic [3:0] nib, input logic last, input logic has_byte,
                        input logic [8:0] em, input logic [8:0] el);
        int n;
        in_valid = 1'b1;
        in_nib   = nib;
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready_m && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready_m) begin
            check("in_ready_timeout", 32'd0, 32'd1);
        end else if (has_byte) begin
            exp_q.push_back(em);
            exp_l.push_back(el);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_l.size() != 0) && n < 500) begin
            n++;
            @(posedge clk);
        end
        if (exp_q.size() != 0 || exp_l.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp_l.delete();
        #1;
        check("in_ready_in_reset", {31'd0, in_ready_m}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int t0;

    initial begin
        total = 0; bad = 0; cyc = 0;
        model_cnt = 16'h0000; hold_seen = 1'b0; hold_val = 9'd0;
        rst_n = 1'b0; in_valid = 1'b0; in_nib = 4'h0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid_m}, 32'd0);
        check("rst_out_data", {24'd0, out_data_m}, 32'h00);
        check("rst_out_last", {31'd0, out_last_m}, 32'd0);
        check("rst_byte_cnt", {16'd0, byte_cnt_m}, 32'd0);
        check("rst_half", {31'd0, half_m}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_m}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // B,3 -> B3 (msb) / 3B (lsb)
        send(4'hB, 1'b0, 1'b0, 9'h000, 9'h000);
        check("half_after_first", {31'd0, half_m}, 32'd1);
        send(4'h3, 1'b0, 1'b1, {1'b0, 8'hB3}, {1'b0, 8'h3B});
        wait_drain();
        check("byte_cnt_after_b3", {16'd0, byte_cnt_m}, 32'd1);
        check("valid_one_cycle", {31'd0, out_valid_m}, 32'd0);

        // Lone nibble with in_last: padded
        send(4'hA, 1'b1, 1'b1, {1'b1, 8'hA0}, {1'b1, 8'h5A});
        check("half_after_lone", {31'd0, half_m}, 32'd0);
        wait_drain();

        // Pair closing a frame
        send(4'h7, 1'b0, 1'b0, 9'h000, 9'h000);
        send(4'hE, 1'b1, 1'b1, {1'b1, 8'h7E}, {1'b1, 8'hE7});
        wait_drain();

        // Back-pressure: B3 pending, 1 accepted, 2 stalled
        out_ready = 1'b0;
        send(4'hB, 1'b0, 1'b0, 9'h000, 9'h000);
        send(4'h3, 1'b0, 1'b1, {1'b0, 8'hB3}, {1'b0, 8'h3B});
        send(4'h1, 1'b0, 1'b0, 9'h000, 9'h000);
        check("half_under_stall", {31'd0, half_m}, 32'd1);
        in_valid = 1'b1; in_nib = 4'h2; in_last = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready_m}, 32'd0);
            check("stall_out_data", {24'd0, out_data_m}, 32'hB3);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(4'h2, 1'b0, 1'b1, {1'b0, 8'h12}, {1'b0, 8'h21});
        check("data_after_stall", {24'd0, out_data_m}, 32'h12);
        wait_drain();

        // Counter preset: 65534 lone-nibble bytes at one per cycle
        do_reset();
        for (int i = 0; i < 65534; i++) begin
            send(4'h0, 1'b1, 1'b1, {1'b1, 8'h00}, {1'b1, 8'h50});
        end
        wait_drain();
        check("byte_cnt_preset", {16'd0, byte_cnt_m}, 32'hFFFE);

        // Continuous stream 1..8, one byte per two cycles, counter wraps
        t0 = cyc;
        send(4'h1, 1'b0, 1'b0, 9'h000, 9'h000);
        send(4'h2, 1'b0, 1'b1, {1'b0, 8'h12}, {1'b0, 8'h21});
        send(4'h3, 1'b0, 1'b0, 9'h000, 9'h000);
        send(4'h4, 1'b0, 1'b1, {1'b0, 8'h34}, {1'b0, 8'h43});
        send(4'h5, 1'b0, 1'b0, 9'h000, 9'h000);
        send(4'h6, 1'b0, 1'b1, {1'b0, 8'h56}, {1'b0, 8'h65});
        send(4'h7, 1'b0, 1'b0, 9'h000, 9'h000);
        send(4'h8, 1'b0, 1'b1, {1'b0, 8'h78}, {1'b0, 8'h87});
        check("stream_cycles", cyc - t0, 32'd8);
        wait_drain();
        check("byte_cnt_wrap", {16'd0, byte_cnt_m}, 32'h0002);

        // Reset with a pending byte and a held nibble
        out_ready = 1'b0;
        send(4'hA, 1'b0, 1'b0, 9'h000, 9'h000);
        send(4'hB, 1'b0, 1'b1, {1'b0, 8'hAB}, {1'b0, 8'hBA});
        send(4'hC, 1'b0, 1'b0, 9'h000, 9'h000);
        check("pre_rst_half", {31'd0, half_m}, 32'd1);
        check("pre_rst_valid", {31'd0, out_valid_m}, 32'd1);
        do_reset();
        check("post_rst_valid", {31'd0, out_valid_m}, 32'd0);
        check("post_rst_half", {31'd0, half_m}, 32'd0);
        check("post_rst_cnt", {16'd0, byte_cnt_m}, 32'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_output_after_rst", {31'd0, out_valid_m}, 32'd0);
        send(4'hC, 1'b0, 1'b0, 9'h000, 9'h000);
        send(4'hD, 1'b0, 1'b1, {1'b0, 8'hCD}, {1'b0, 8'hDC});
        wait_drain();
        check("cnt_after_cd", {16'd0, byte_cnt_m}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
